// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-lite main control: opcodes, states,
// ALU/mux selects and the strobe bundle driven into the datapath.
package mips_ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned SEL_W   = 2;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11
    } state_e;

    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] ALUB_REG    = 2'b00;
    localparam logic [SEL_W-1:0] ALUB_FOUR   = 2'b01;
    localparam logic [SEL_W-1:0] ALUB_IMM    = 2'b10;
    localparam logic [SEL_W-1:0] ALUB_IMMSH2 = 2'b11;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic             pcwrite;
        logic             pcwritecond;
        logic             iord;
        logic             memread;
        logic             memwrite;
        logic             irwrite;
        logic             memtoreg;
        logic             regdst;
        logic             regwrite;
        logic             alusrca;
        logic [SEL_W-1:0] alusrcb;
        logic [SEL_W-1:0] pcsource;
        logic [SEL_W-1:0] aluop;
    } ctrl_t;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Moore strobe decode: maps the current control state to its datapath strobes.
module mc_out_decode
    import mips_ctrl_pkg::*;
(
    input  state_e state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.memread = 1'b1;
                ctrl.irwrite = 1'b1;
                ctrl.pcwrite = 1'b1;
                ctrl.alusrcb = ALUB_FOUR;
            end
            S_DECODE: ctrl.alusrcb = ALUB_IMMSH2;
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUB_IMM;
            end
            S_MEMRD: begin
                ctrl.memread = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.memwrite = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_EXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUB_REG;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca     = 1'b1;
                ctrl.alusrcb     = ALUB_REG;
                ctrl.aluop       = ALUOP_SUB;
                ctrl.pcwritecond = 1'b1;
                ctrl.pcsource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pcwrite  = 1'b1;
                ctrl.pcsource = PCSRC_JUMP;
            end
            S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_ADDIWB: ctrl.regwrite = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_main_control.sv
// Multicycle MIPS-lite main control: instruction sequencing, strobe gating,
// sticky illegal-opcode flag and retired-instruction counter.
module mc_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic             mem_ready,
    output logic             pcwrite,
    output logic             pcwritecond,
    output logic             iord,
    output logic             memread,
    output logic             memwrite,
    output logic             irwrite,
    output logic             memtoreg,
    output logic             regdst,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsource,
    output logic             aluop1,
    output logic             aluop0,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state_dbg
);

    state_e state;
    state_e state_nxt;
    ctrl_t  dec;
    ctrl_t  ctrl;
    logic   op_ok;
    logic   retire;

    assign op_ok = op_legal(op);

    mc_out_decode u_dec (
        .state (state),
        .ctrl  (dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state sequencing; op is only consulted in DECODE and MEMADR.
    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:   state_nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_EXEC;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    default:      state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR:  state_nxt = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_nxt = S_FETCH;
            S_MEMWR:   state_nxt = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:    state_nxt = S_RTYPEWB;
            S_RTYPEWB: state_nxt = S_FETCH;
            S_BRANCH:  state_nxt = S_FETCH;
            S_JUMP:    state_nxt = S_FETCH;
            S_ADDIEX:  state_nxt = S_ADDIWB;
            S_ADDIWB:  state_nxt = S_FETCH;
            default:   state_nxt = S_FETCH;
        endcase
    end

    // Fetch strobes wait on memory; illegal decode and reset silence everything.
    always_comb begin
        ctrl = dec;
        if (state == S_FETCH) begin
            ctrl.irwrite = dec.irwrite & mem_ready;
            ctrl.pcwrite = dec.pcwrite & mem_ready;
        end
        if ((state == S_DECODE) && !op_ok) begin
            ctrl = '0;
        end
        if (!rst_n) begin
            ctrl = '0;
        end
    end

    always_comb begin
        retire = 1'b0;
        case (state)
            S_MEMWB, S_RTYPEWB, S_BRANCH, S_JUMP, S_ADDIWB: retire = 1'b1;
            S_MEMWR:                                        retire = mem_ready;
            default:                                        retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_op  <= 1'b0;
            instr_count <= '0;
        end else begin
            if ((state == S_DECODE) && !op_ok) begin
                illegal_op <= 1'b1;
            end
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    assign pcwrite     = ctrl.pcwrite;
    assign pcwritecond = ctrl.pcwritecond;
    assign iord        = ctrl.iord;
    assign memread     = ctrl.memread;
    assign memwrite    = ctrl.memwrite;
    assign irwrite     = ctrl.irwrite;
    assign memtoreg    = ctrl.memtoreg;
    assign regdst      = ctrl.regdst;
    assign regwrite    = ctrl.regwrite;
    assign alusrca     = ctrl.alusrca;
    assign alusrcb     = ctrl.alusrcb;
    assign pcsource    = ctrl.pcsource;
    assign aluop1      = ctrl.aluop[1];
    assign aluop0      = ctrl.aluop[0];
    assign state_dbg   = 4'(state);

endmodule

// File: tb/tb_mc_main_control.sv
// Randomized bench for mc_main_control against an instruction-level path/strobe model.
module tb_mc_main_control;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_ADDI = 6'b001000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  op = '0;
    logic        mem_ready = 1'b1;

    logic        pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic        memtoreg, regdst, regwrite, alusrca, aluop1, aluop0, illegal_op;
    logic [1:0]  alusrcb, pcsource;
    logic [15:0] instr_count;
    logic [3:0]  state_dbg;

    logic        pcwrite4, pcwritecond4, iord4, memread4, memwrite4, irwrite4;
    logic        memtoreg4, regdst4, regwrite4, alusrca4, aluop1_4, aluop0_4, illegal_op4;
    logic [1:0]  alusrcb4, pcsource4;
    logic [3:0]  instr_count4;
    logic [3:0]  state_dbg4;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;
    logic exp_ill = 1'b0;

    always #5 clk = ~clk;

    mc_main_control dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
        .memwrite(memwrite), .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsource(pcsource),
        .aluop1(aluop1), .aluop0(aluop0), .illegal_op(illegal_op),
        .instr_count(instr_count), .state_dbg(state_dbg)
    );

    mc_main_control #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .pcwrite(pcwrite4), .pcwritecond(pcwritecond4), .iord(iord4), .memread(memread4),
        .memwrite(memwrite4), .irwrite(irwrite4), .memtoreg(memtoreg4), .regdst(regdst4),
        .regwrite(regwrite4), .alusrca(alusrca4), .alusrcb(alusrcb4), .pcsource(pcsource4),
        .aluop1(aluop1_4), .aluop0(aluop0_4), .illegal_op(illegal_op4),
        .instr_count(instr_count4), .state_dbg(state_dbg4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic legal(input logic [5:0] o);
        return o inside {T_R, T_LW, T_SW, T_BEQ, T_J, T_ADDI};
    endfunction

    // Strobe vector {pcwrite,pcwritecond,iord,memread,memwrite,irwrite,memtoreg,regdst,regwrite,alusrca,alusrcb,pcsource,aluop}
    function automatic logic [15:0] exp_vec(input int st, input logic mr, input logic [5:0] o);
        logic pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, asa;
        logic [1:0] bsel, psel, aop;
        {pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, asa} = '0;
        bsel = 2'b00; psel = 2'b00; aop = 2'b00;
        case (st)
            0:  begin mrd = 1; bsel = 2'b01; irw = mr; pw = mr; end
            1:  if (legal(o)) bsel = 2'b11;
            2:  begin asa = 1; bsel = 2'b10; end
            3:  begin mrd = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; io = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 2'b01; pwc = 1; psel = 2'b01; end
            9:  begin pw = 1; psel = 2'b10; end
            10: begin asa = 1; bsel = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, asa, bsel, psel, aop};
    endfunction

    function automatic logic [15:0] obs_vec();
        return {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
                regdst, regwrite, alusrca, alusrcb, pcsource, aluop1, aluop0};
    endfunction

    function automatic logic [15:0] obs_vec4();
        return {pcwrite4, pcwritecond4, iord4, memread4, memwrite4, irwrite4, memtoreg4,
                regdst4, regwrite4, alusrca4, alusrcb4, pcsource4, aluop1_4, aluop0_4};
    endfunction

    task automatic check_all(input int st, input logic [5:0] o);
        chk("state", 32'(state_dbg), 32'(st));
        chk("strobes", 32'(obs_vec()), 32'(exp_vec(st, mem_ready, o)));
        chk("strobes4", 32'(obs_vec4()), 32'(exp_vec(st, mem_ready, o)));
        chk("illegal", 32'(illegal_op), 32'(exp_ill));
        chk("count", 32'(instr_count), 32'(exp_cnt % 65536));
        chk("count4", 32'(instr_count4), 32'(exp_cnt % 16));
    endtask

    // Entered just after a falling edge; spends one or more cycles in state st.
    task automatic step_state(input int st, input logic [5:0] o, input int low_cycles);
        int n = 0;
        logic leave;
        do begin
            if (low_cycles >= 0 && (st == 3 || st == 5))
                mem_ready = (n < low_cycles) ? 1'b0 : 1'b1;
            else
                mem_ready = ($urandom_range(0, 3) != 0);
            #1;
            check_all(st, o);
            leave = !(st == 0 || st == 3 || st == 5) || mem_ready;
            n++;
            @(negedge clk);
        end while (!leave && n < 60);
        if (!leave) chk("wait_bound", 32'(0), 32'(1));
    endtask

    task automatic run_instr(input logic [5:0] o, input int low_cycles);
        int path[$];
        op = o;
        path.push_back(0);
        path.push_back(1);
        case (o)
            T_R:    begin path.push_back(6); path.push_back(7); end
            T_LW:   begin path.push_back(2); path.push_back(3); path.push_back(4); end
            T_SW:   begin path.push_back(2); path.push_back(5); end
            T_BEQ:  path.push_back(8);
            T_J:    path.push_back(9);
            T_ADDI: begin path.push_back(10); path.push_back(11); end
            default: ;
        endcase
        foreach (path[i]) begin
            step_state(path[i], o, low_cycles);
            if (path[i] == 1 && !legal(o)) exp_ill = 1'b1;
        end
        if (legal(o)) exp_cnt++;
    endtask

    initial begin
        logic [5:0] tbl [6];
        tbl[0] = T_R; tbl[1] = T_LW; tbl[2] = T_SW;
        tbl[3] = T_BEQ; tbl[4] = T_J; tbl[5] = T_ADDI;

        // Reset held: strobes silent even though FETCH would read memory.
        rst_n = 1'b0; mem_ready = 1'b1; op = T_R;
        @(negedge clk); #1;
        chk("rst_strobes", 32'(obs_vec()), 32'(0));
        chk("rst_state", 32'(state_dbg), 32'(0));
        chk("rst_count", 32'(instr_count), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_memread", 32'(memread), 32'(1));
        chk("post_rst_irwrite", 32'(irwrite), 32'(1));
        chk("post_rst_state", 32'(state_dbg), 32'(0));

        run_instr(T_R, -1);
        run_instr(T_LW, 3);
        run_instr(T_BEQ, -1);
        run_instr(T_SW, 2);
        run_instr(6'b111111, -1);
        run_instr(T_ADDI, -1);
        run_instr(T_J, -1);

        // Abandon a store mid-wait with an asynchronous reset.
        op = T_SW;
        step_state(0, T_SW, -1);
        step_state(1, T_SW, -1);
        step_state(2, T_SW, -1);
        mem_ready = 1'b0;
        #1;
        check_all(5, T_SW);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_strobes", 32'(obs_vec()), 32'(0));
        chk("async_strobes4", 32'(obs_vec4()), 32'(0));
        chk("async_state", 32'(state_dbg), 32'(0));
        chk("async_count", 32'(instr_count), 32'(0));
        chk("async_illegal", 32'(illegal_op), 32'(0));
        exp_cnt = 0;
        exp_ill = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Random mix; the 4-bit counter wraps several times.
        for (int k = 0; k < 60; k++) begin
            int r;
            logic [5:0] o;
            r = int'($urandom_range(0, 7));
            if (r < 6) o = tbl[r];
            else       o = 6'($urandom());
            run_instr(o, ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 4)));
        end
        #1;
        chk("final_count", 32'(instr_count), 32'(exp_cnt % 65536));
        chk("final_count4", 32'(instr_count4), 32'(exp_cnt % 16));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
